dnn_result_capture: RTL
=======================

// Module: dnn_result_capture
// PURPOSE
//  Captures DNN output activations, one sample per DNN cycle strobe (cycle_clk), into an
//  on-chip buffer for host/LED/UART readback. Parametrised successor to the fixed 200x10b
//  output store: N lanes, configurable depth and skip count, stop-on-full or circular mode,
//  and a registered logical-index read port. Sits between DNN_top and the readback logic.
// PARAMETERS
//  LANES   1    number of CH_W-bit lanes captured per strobe
//  CH_W    10   bits per lane
//  DEPTH   200  entries per lane (>=2)
//  SKIP    0    leading strobes discarded after reset/clear
//  CIRC    0    0 = stop when full (done asserts); 1 = circular, overwrite oldest
//  AW      $clog2(DEPTH)  address/count width (derived; count uses AW+1 bits)
// PORTS
//  clk        in   1            capture and readback clock (DNN clock domain)
//  resetn     in   1            asynchronous, active-low reset
//  clear      in   1            synchronous restart: empty buffer, re-arm skip
//  en         in   1            capture enable; strobes are ignored while low
//  cap_stb    in   1            one-cycle capture strobe (cycle_clk)
//  cap_data   in   LANES*CH_W   lane i = cap_data[i*CH_W +: CH_W]
//  rd_addr    in   AW           logical index, 0 = oldest stored entry
//  rd_lane    in   clog2(LANES) lane select (1 bit when LANES==1, ignored)
//  rd_data    out  CH_W         registered read data
//  rd_oob     out  1            registered: rd_addr >= count at sample time
//  count      out  AW+1         valid entries, 0..DEPTH
//  done       out  1            CIRC=0: buffer full, capture halted (drives clock-gate stop)
//  wrapped    out  1            CIRC=1: at least one entry overwritten (sticky)
// BEHAVIOUR
//  Reset: count=0, wr_ptr=0, skip_cnt=0, done=0, wrapped=0, rd_data=0, rd_oob=1.
//   RAM contents are not reset; stale data is unreachable because out-of-range reads are masked.
//  Accepted strobe = cap_stb & en & ~clear & ~done.
//   - skip_cnt<SKIP: skip_cnt++, nothing written.
//   - Otherwise: all lanes written at wr_ptr; wr_ptr = (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
//  CIRC=0: count++ per write; done=1 in the cycle after the write that makes count==DEPTH.
//   Later strobes are ignored. done clears only on clear or reset.
//  CIRC=1: count saturates at DEPTH; a write with count==DEPTH sets wrapped and advances
//   oldest (oldest = wr_ptr when full, 0 otherwise). done stays 0.
//  Read: physical = (oldest + rd_addr) mod DEPTH, computed without a divider (one compare,
//   one subtract). rd_data/rd_oob are valid 1 cycle after rd_addr/rd_lane are sampled.
//   rd_oob=1 forces rd_data=0.
//  Write/read collision (same physical address, same cycle): rd_data returns the OLD contents.
//  clear: next cycle count=0, wr_ptr=0, skip_cnt=0, done=0, wrapped=0. clear takes priority
//   over a simultaneous strobe; that strobe is lost.
//  Reset asserted mid-operation: all state returns to reset values asynchronously; no partial write.
//  Widths: lane slicing is fixed little-endian. count never exceeds DEPTH. There is no arithmetic
//   on sample data.
// STRUCTURE
//  dnn_capture_defs.vh: CAP_MODE_STOP/CAP_MODE_CIRC localparams and the lane-slice macro,
//   shared with the readback/UART formatter.
//  Sub-module capture_sdp_ram: simple dual-port RAM, DEPTH x (LANES*CH_W), synchronous write,
//   registered read, read-old-on-collision; infers BRAM. The top holds the pointers, skip,
//   count, done/wrapped flags and the lane mux after the RAM register.
// TESTING
//  1 Defaults: 205 strobes with data=k -> done after strobe 200; count=200; addr 0/199 read 0/199;
//    addr 200 -> rd_oob=1, data 0.
//  2 SKIP=2, DEPTH=4: strobes data 1..6 -> stored 3,4,5,6; done=1; strobes 7..9 ignored.
//  3 CIRC=1, DEPTH=4: strobes 1..6 -> count=4, wrapped=1; logical 0..3 read 3,4,5,6.
//  4 LANES=3, CH_W=8: cap_data=0x332211 -> lanes 0/1/2 read 0x11/0x22/0x33.
//  5 clear coincident with cap_stb at count=2 -> count=0, strobe dropped, next strobe lands at addr 0.
//  6 resetn pulsed low mid-capture (async, between edges) -> outputs at reset values immediately;
//    capture restarts cleanly after release.

Source files
------------

// File: rtl/dnn_result_capture_pkg.sv
// Shared constants and helpers for the DNN result capture buffer and its readback logic.
package dnn_result_capture_pkg;

  // Capture modes: stop when the buffer fills, or keep overwriting the oldest entry.
  localparam int CAP_MODE_STOP = 0;
  localparam int CAP_MODE_CIRC = 1;

  // Bit offset of a lane inside a packed capture word; lanes are little-endian, lane 0 at bit 0.
  function automatic int lane_lsb(input int lane, input int ch_w);
    return lane * ch_w;
  endfunction

endpackage

// File: rtl/dnn_result_capture_sdp_ram.sv
// Simple dual-port sample store: one synchronous write port, one registered read port.
// A read of the address being written in the same cycle returns the previous contents.
module dnn_result_capture_sdp_ram #(
  parameter int DEPTH = 200,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write and registered read share one clocked block so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dnn_result_capture.sv
// Captures one multi-lane DNN output sample per cycle strobe into a buffer and serves
// registered reads by logical index (0 = oldest stored entry).
module dnn_result_capture
  import dnn_result_capture_pkg::*;
#(
  parameter int LANES = 1,
  parameter int CH_W  = 10,
  parameter int DEPTH = 200,
  parameter int SKIP  = 0,
  parameter int CIRC  = CAP_MODE_STOP,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  cap_stb,
  input  logic [LANES*CH_W-1:0] cap_data,
  input  logic [AW-1:0]         rd_addr,
  input  logic [LW-1:0]         rd_lane,
  output logic [CH_W-1:0]       rd_data,
  output logic                  rd_oob,
  output logic [AW:0]           count,
  output logic                  done,
  output logic                  wrapped
);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL       = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_COUNT = (AW+1)'(DEPTH - 1);
  localparam bit            IS_CIRC    = (CIRC == CAP_MODE_CIRC);

  logic [AW-1:0]         wr_ptr;
  logic                  full;
  logic                  accept;
  logic                  skipping;
  logic                  wr_en;
  logic [AW-1:0]         oldest;
  logic [AW:0]           rd_sum;
  logic [AW-1:0]         rd_phys;
  logic [LANES*CH_W-1:0] ram_q;
  logic [LW-1:0]         lane_q;
  logic                  oob_q;
  logic [CH_W-1:0]       lane_word;

  assign full   = (count == FULL);
  assign accept = cap_stb & en & ~clear & ~done;
  assign wr_en  = accept & ~skipping;

  if (SKIP > 0) begin : g_skip
    localparam int SW = $clog2(SKIP + 1);
    localparam logic [SW-1:0] SKIP_V = SW'(SKIP);
    logic [SW-1:0] skip_cnt;

    // Count off the leading strobes that are discarded after reset or clear.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        skip_cnt <= '0;
      end else if (clear) begin
        skip_cnt <= '0;
      end else if (accept && (skip_cnt != SKIP_V)) begin
        skip_cnt <= skip_cnt + 1'b1;
      end
    end

    assign skipping = (skip_cnt != SKIP_V);
  end else begin : g_no_skip
    assign skipping = 1'b0;
  end

  // Write pointer, fill count and the done/wrapped status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      count   <= '0;
      done    <= 1'b0;
      wrapped <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      count   <= '0;
      done    <= 1'b0;
      wrapped <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
      if (!full) begin
        count <= count + 1'b1;
      end
      if (IS_CIRC) begin
        if (full) begin
          wrapped <= 1'b1;
        end
      end else if (count == LAST_COUNT) begin
        done <= 1'b1;
      end
    end
  end

  // Once a circular buffer is full the next write slot also holds the oldest entry.
  assign oldest  = (IS_CIRC && full) ? wr_ptr : '0;
  assign rd_sum  = {1'b0, oldest} + {1'b0, rd_addr};
  assign rd_phys = AW'((rd_sum >= FULL) ? rd_sum - FULL : rd_sum);

  dnn_result_capture_sdp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (LANES * CH_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (cap_data),
    .raddr (rd_phys),
    .rdata (ram_q)
  );

  // Lane select and range flag follow the RAM read register so all three line up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane_q <= '0;
      oob_q  <= 1'b1;
    end else begin
      lane_q <= rd_lane;
      oob_q  <= ({1'b0, rd_addr} >= count);
    end
  end

  // Pick the requested lane out of the registered word; a single-lane build ignores rd_lane.
  always_comb begin
    lane_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((LANES == 1) || (lane_q == LW'(i))) begin
        lane_word = ram_q[lane_lsb(i, CH_W) +: CH_W];
      end
    end
  end

  assign rd_data = oob_q ? '0 : lane_word;
  assign rd_oob  = oob_q;

endmodule
